// File: rtl/uart_port_arbiter_if.sv
// Shared-UART access bundle: two requesters on one side, the UART register port on the other.
interface uart_port_arbiter_if;
    // requester 0
    logic        m0_valid;
    logic        m0_wen;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ready;
    logic        m0_resp;
    logic [31:0] m0_rdata;
    logic        m0_err;
    // requester 1
    logic        m1_valid;
    logic        m1_wen;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ready;
    logic        m1_resp;
    logic [31:0] m1_rdata;
    logic        m1_err;
    // UART register port
    logic [31:0] u_raddr;
    logic        u_rvalid;
    logic [31:0] u_rdata;
    logic [31:0] u_waddr;
    logic [31:0] u_wdata;
    logic        u_wvalid;

    // arbiter side
    modport slave (
        input  m0_valid, m0_wen, m0_addr, m0_wdata,
        input  m1_valid, m1_wen, m1_addr, m1_wdata,
        input  u_rdata,
        output m0_ready, m0_resp, m0_rdata, m0_err,
        output m1_ready, m1_resp, m1_rdata, m1_err,
        output u_raddr, u_rvalid, u_waddr, u_wdata, u_wvalid
    );

    // requesters plus UART model side
    modport master (
        output m0_valid, m0_wen, m0_addr, m0_wdata,
        output m1_valid, m1_wen, m1_addr, m1_wdata,
        output u_rdata,
        input  m0_ready, m0_resp, m0_rdata, m0_err,
        input  m1_ready, m1_resp, m1_rdata, m1_err,
        input  u_raddr, u_rvalid, u_waddr, u_wdata, u_wvalid
    );
endinterface

// File: rtl/uart_port_arbiter.sv
// Round-robin arbiter sharing one UART register port between two requesters.
// Each grant runs accept -> single strobe -> response; stray addresses are
// answered locally with err so the UART FIFOs never move on them.
module uart_port_arbiter #(
    parameter logic [31:0] SERIAL_PORT = 32'ha00003f8
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_port_arbiter_if.slave  bus
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            id_q, id_d;
    logic            wen_q, wen_d;
    logic            hit_q, hit_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   raddr_q, raddr_d;
    logic            wvalid_q, wvalid_d;
    logic [DW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   uwdata_q, uwdata_d;

    logic [1:0]      resp_q, resp_d;
    logic [1:0]      err_q, err_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;

    logic            win_c;
    logic            sel_wen_c;
    logic [DW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_wdata_c;
    logic            sel_hit_c;
    logic [1:0]      grant_c;

    // Winner choice: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        win_c       = 1'b0;
        sel_wen_c   = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        if (bus.m0_valid && bus.m1_valid) begin
            win_c = ~last_q;
        end else begin
            win_c = bus.m1_valid;
        end
        if (win_c) begin
            sel_wen_c   = bus.m1_wen;
            sel_addr_c  = bus.m1_addr;
            sel_wdata_c = bus.m1_wdata;
        end else begin
            sel_wen_c   = bus.m0_wen;
            sel_addr_c  = bus.m0_addr;
            sel_wdata_c = bus.m0_wdata;
        end
        sel_hit_c = (sel_addr_c == SERIAL_PORT);
    end

    // Next-state and next-output logic; strobes and responses default to idle (0).
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        wen_d    = wen_q;
        hit_d    = hit_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        raddr_d  = '0;
        wvalid_d = 1'b0;
        waddr_d  = '0;
        uwdata_d = '0;
        resp_d   = 2'b00;
        err_d    = 2'b00;
        rdata0_d = '0;
        rdata1_d = '0;
        grant_c  = 2'b00;

        unique case (state_q)
            IDLE: begin
                // rst_n gates ready so nothing is accepted while reset is held
                if ((bus.m0_valid || bus.m1_valid) && rst_n) begin
                    grant_c[win_c] = 1'b1;
                    id_d    = win_c;
                    last_d  = win_c;
                    wen_d   = sel_wen_c;
                    addr_d  = sel_addr_c;
                    wdata_d = sel_wdata_c;
                    hit_d   = sel_hit_c;
                    // strobe registers load now so the pulse appears in ISSUE
                    if (sel_hit_c && !sel_wen_c) begin
                        rvalid_d = 1'b1;
                        raddr_d  = sel_addr_c;
                    end
                    if (sel_hit_c && sel_wen_c) begin
                        wvalid_d = 1'b1;
                        waddr_d  = sel_addr_c;
                        uwdata_d = sel_wdata_c;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // UART read data is sampled on the edge that closes the read strobe
                resp_d[id_q] = 1'b1;
                err_d[id_q]  = ~hit_q;
                if (hit_q && !wen_q) begin
                    if (id_q) begin
                        rdata1_d = bus.u_rdata;
                    end else begin
                        rdata0_d = bus.u_rdata;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latch and registered outputs; reset withdraws any strobe in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            wen_q    <= 1'b0;
            hit_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            raddr_q  <= '0;
            wvalid_q <= 1'b0;
            waddr_q  <= '0;
            uwdata_q <= '0;
            resp_q   <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            wen_q    <= wen_d;
            hit_q    <= hit_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            raddr_q  <= raddr_d;
            wvalid_q <= wvalid_d;
            waddr_q  <= waddr_d;
            uwdata_q <= uwdata_d;
            resp_q   <= resp_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.m0_ready = grant_c[0];
    assign bus.m1_ready = grant_c[1];
    assign bus.m0_resp  = resp_q[0];
    assign bus.m1_resp  = resp_q[1];
    assign bus.m0_err   = err_q[0];
    assign bus.m1_err   = err_q[1];
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;
    assign bus.u_rvalid = rvalid_q;
    assign bus.u_raddr  = raddr_q;
    assign bus.u_wvalid = wvalid_q;
    assign bus.u_waddr  = waddr_q;
    assign bus.u_wdata  = uwdata_q;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction schedule model.
module tb_uart_port_arbiter;

    localparam logic [31:0] SP = 32'ha00003f8;

    logic clk;
    logic rst_n;
    uart_port_arbiter_if bus ();

    uart_port_arbiter #(.SERIAL_PORT(SP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // UART model: RX FIFO of bytes, read data is the head or 0xff when empty
    logic [7:0] rx_mem [1024];
    int rx_rd = 0;
    int rx_wr = 0;
    assign bus.u_rdata = (rx_rd != rx_wr) ? {24'h0, rx_mem[rx_rd]} : 32'hff;
    always @(posedge clk) begin
        if (bus.u_rvalid && (rx_rd != rx_wr)) rx_rd <= rx_rd + 1;
    end

    task automatic rx_push(input logic [7:0] b);
        if (rx_wr < 1020) begin
            rx_mem[rx_wr] = b;
            rx_wr = rx_wr + 1;
        end
    endtask

    // Reference model: a grant at cycle c schedules the strobe at c+1 and the
    // response at c+2; the port is free again at c+3.
    typedef struct packed {
        logic        rv;
        logic        wv;
        logic        rid;
        logic [1:0]  resp;
        logic [1:0]  err;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
    } exp_t;

    exp_t ring [4];
    exp_t e;
    int   cyc = 0;
    int   m_free = 0;
    logic m_last = 1'b1;
    logic er0, er1, w, hit, wen;
    logic [31:0] a, wd;
    logic rs0 = 1'b0;
    logic rs1 = 1'b0;

    initial for (int i = 0; i < 4; i++) ring[i] = '0;

    // Per-cycle compare against the model
    always @(negedge clk) begin
        e   = ring[cyc % 4];
        er0 = 1'b0;
        er1 = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) ring[i] = '0;
            e      = '0;
            m_last = 1'b1;
            m_free = cyc + 1;
        end else begin
            if (e.rv) begin
                if (e.rid) ring[(cyc + 1) % 4].rdata1 = bus.u_rdata;
                else       ring[(cyc + 1) % 4].rdata0 = bus.u_rdata;
            end
            if (cyc >= m_free && (bus.m0_valid || bus.m1_valid)) begin
                if (bus.m0_valid && bus.m1_valid) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
                else                              w = bus.m1_valid;
                er0    = (w == 1'b0);
                er1    = (w == 1'b1);
                m_last = w;
                a   = w ? bus.m1_addr  : bus.m0_addr;
                wen = w ? bus.m1_wen   : bus.m0_wen;
                wd  = w ? bus.m1_wdata : bus.m0_wdata;
                hit = (a == SP);
                if (hit && !wen) begin
                    ring[(cyc + 1) % 4].rv    = 1'b1;
                    ring[(cyc + 1) % 4].raddr = a;
                    ring[(cyc + 1) % 4].rid   = w;
                end
                if (hit && wen) begin
                    ring[(cyc + 1) % 4].wv    = 1'b1;
                    ring[(cyc + 1) % 4].waddr = a;
                    ring[(cyc + 1) % 4].wdata = wd;
                end
                ring[(cyc + 2) % 4].resp[w] = 1'b1;
                ring[(cyc + 2) % 4].err[w]  = ~hit;
                m_free = cyc + 3;
            end
        end
        chk("m0_ready", 32'(bus.m0_ready), 32'(er0));
        chk("m1_ready", 32'(bus.m1_ready), 32'(er1));
        chk("m0_resp",  32'(bus.m0_resp),  32'(e.resp[0]));
        chk("m1_resp",  32'(bus.m1_resp),  32'(e.resp[1]));
        chk("m0_err",   32'(bus.m0_err),   32'(e.err[0]));
        chk("m1_err",   32'(bus.m1_err),   32'(e.err[1]));
        chk("m0_rdata", bus.m0_rdata, e.rdata0);
        chk("m1_rdata", bus.m1_rdata, e.rdata1);
        chk("u_rvalid", 32'(bus.u_rvalid), 32'(e.rv));
        chk("u_raddr",  bus.u_raddr, e.raddr);
        chk("u_wvalid", 32'(bus.u_wvalid), 32'(e.wv));
        chk("u_waddr",  bus.u_waddr, e.waddr);
        chk("u_wdata",  bus.u_wdata, e.wdata);
        ring[cyc % 4] = '0;
        rs0 = bus.m0_ready;
        rs1 = bus.m1_ready;
        cyc++;
    end

    task automatic set_req(input logic m, input logic v, input logic wn,
                           input logic [31:0] ad, input logic [31:0] d);
        if (m) begin
            bus.m1_valid = v; bus.m1_wen = wn; bus.m1_addr = ad; bus.m1_wdata = d;
        end else begin
            bus.m0_valid = v; bus.m0_wen = wn; bus.m0_addr = ad; bus.m0_wdata = d;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One transaction from an idle port; entered and left at posedge+1
    task automatic do_txn(input logic m, input logic wn, input logic [31:0] ad, input logic [31:0] d,
                          output logic s_rv, output logic s_wv, output logic [31:0] s_wd,
                          output logic r_resp, output logic r_err, output logic [31:0] r_rdata,
                          output logic tail);
        logic got;
        got = 1'b0;
        set_req(m, 1'b1, wn, ad, d);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = m ? bus.m1_ready : bus.m0_ready;
            if (!got) begin @(posedge clk); #1; end
        end
        chk("grant_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        s_rv = bus.u_rvalid;
        s_wv = bus.u_wvalid;
        s_wd = bus.u_wdata;
        @(negedge clk);
        r_resp  = m ? bus.m1_resp  : bus.m0_resp;
        r_err   = m ? bus.m1_err   : bus.m0_err;
        r_rdata = m ? bus.m1_rdata : bus.m0_rdata;
        tail    = bus.u_rvalid | bus.u_wvalid;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        return ($urandom % 4 != 0) ? SP : $urandom;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic s_rv, s_wv, r_resp, r_err, tail, v, rs;
    logic [31:0] s_wd, r_rdata;
    int gids [$];
    int gcyc [$];

    initial begin
        rst_n = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m0_ready", 32'(bus.m0_ready), 32'd0);
        chk("rst_m0_resp",  32'(bus.m0_resp),  32'd0);
        chk("rst_m1_rdata", bus.m1_rdata, 32'd0);
        chk("rst_u_rvalid", 32'(bus.u_rvalid), 32'd0);
        chk("rst_u_wvalid", 32'(bus.u_wvalid), 32'd0);
        chk("rst_u_waddr",  bus.u_waddr, 32'd0);
        rst_n = 1'b1;

        // single write of 0x41
        do_txn(1'b0, 1'b1, SP, 32'h41, s_rv, s_wv, s_wd, r_resp, r_err, r_rdata, tail);
        chk("wr_wvalid", 32'(s_wv), 32'd1);
        chk("wr_rvalid", 32'(s_rv), 32'd0);
        chk("wr_wdata",  32'(s_wd[7:0]), 32'h41);
        chk("wr_resp",   32'(r_resp), 32'd1);
        chk("wr_err",    32'(r_err), 32'd0);

        // read with RX empty
        do_txn(1'b1, 1'b0, SP, 32'h0, s_rv, s_wv, s_wd, r_resp, r_err, r_rdata, tail);
        chk("rde_rvalid", 32'(s_rv), 32'd1);
        chk("rde_single", 32'(tail), 32'd0);
        chk("rde_rdata",  r_rdata, 32'hff);
        chk("rde_err",    32'(r_err), 32'd0);

        // read with 0x5a queued, then confirm a single pop
        rx_push(8'h5a);
        do_txn(1'b0, 1'b0, SP, 32'h0, s_rv, s_wv, s_wd, r_resp, r_err, r_rdata, tail);
        chk("rd5a_rdata", r_rdata, 32'h5a);
        do_txn(1'b0, 1'b0, SP, 32'h0, s_rv, s_wv, s_wd, r_resp, r_err, r_rdata, tail);
        chk("rd5a_after", r_rdata, 32'hff);

        // bad address
        do_txn(1'b0, 1'b0, 32'ha0000000, 32'h0, s_rv, s_wv, s_wd, r_resp, r_err, r_rdata, tail);
        chk("bad_strobe", 32'(s_rv | s_wv | tail), 32'd0);
        chk("bad_resp",   32'(r_resp), 32'd1);
        chk("bad_err",    32'(r_err), 32'd1);
        chk("bad_rdata",  r_rdata, 32'd0);

        // contention straight after reset
        apply_reset();
        set_req(1'b0, 1'b1, 1'b1, SP, 32'h30);
        set_req(1'b1, 1'b1, 1'b1, SP, 32'h31);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.m0_ready) begin gids.push_back(0); gcyc.push_back(i); end
            if (bus.m1_ready) begin gids.push_back(1); gcyc.push_back(i); end
            if (gids.size() >= 8) break;
            @(posedge clk); #1;
            bus.m0_wdata = 32'($urandom_range(0, 255));
            bus.m1_wdata = 32'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("cont_count", 32'(gids.size()), 32'd8);
        for (int i = 0; i < gids.size(); i++) begin
            chk("cont_order", 32'(gids[i]), 32'(i % 2));
            if (i > 0) chk("cont_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        repeat (3) @(posedge clk);
        #1;

        // reset during the ISSUE cycle of a write
        set_req(1'b0, 1'b1, 1'b1, SP, 32'h77);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort_wvalid_before", 32'(bus.u_wvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wvalid_after", 32'(bus.u_wvalid), 32'd0);
        chk("abort_wdata_after",  bus.u_wdata, 32'd0);
        set_req(1'b0, 1'b1, 1'b0, 32'ha0000004, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'ha0000008, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_no_resp", 32'(bus.m0_resp), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_tie_m0", 32'(bus.m0_ready), 32'd1);
        chk("abort_tie_m1", 32'(bus.m1_ready), 32'd0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        begin
            logic got1;
            got1 = 1'b0;
            for (int i = 0; i < 10 && !got1; i++) begin
                @(negedge clk);
                got1 = bus.m1_ready;
                if (!got1) begin @(posedge clk); #1; end
            end
            chk("abort_m1_next", 32'(got1), 32'd1);
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                v  = (m == 1) ? bus.m1_valid : bus.m0_valid;
                rs = (m == 1) ? rs1 : rs0;
                if (v && rs) begin
                    set_req(1'(m), 1'b0, 1'b0, 32'h0, 32'h0);
                    if ($urandom % 2 == 0)
                        set_req(1'(m), 1'b1, 1'($urandom % 2), rnd_addr(), $urandom);
                end else if (!v && ($urandom % 3 == 0)) begin
                    set_req(1'(m), 1'b1, 1'($urandom % 2), rnd_addr(), $urandom);
                end else if (v && ($urandom % 4 == 0)) begin
                    set_req(1'(m), 1'b1, 1'($urandom % 2), rnd_addr(), $urandom);
                end
            end
            if ($urandom % 8 == 0) rx_push(8'($urandom));
        end
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_port_arbiter.md
# uart_port_arbiter

Two-requester round-robin arbiter that shares the single UART register port (read strobe, write strobe, 32-bit address/data) between two bus masters, for example the fetch and load/store units. Each granted transaction runs a fixed three-phase sequence: accept, issue a single strobe to the UART, then return a response. Addresses outside the UART's register are answered locally with an error flag, so the UART's FIFO pointers never move on stray accesses.

## Interface
- SERIAL_PORT, 32'ha00003f8: the only address forwarded to the UART.
- clock  in  1: single clock, all state on rising edge.
- reset  in  1: asynchronous, active-low; asserted (0) clears all state immediately.
- m0_valid / m1_valid  in  1: request present; held until the matching ready.
- m0_wen / m1_wen  in  1: 1 = write, 0 = read.
- m0_addr / m1_addr  in  32: request address.
- m0_wdata / m1_wdata  in  32: write data; only [7:0] is meaningful to the UART.
- m0_ready / m1_ready  out  1: request accepted this cycle (combinational in IDLE).
- m0_resp / m1_resp  out  1: one-cycle response pulse.
- m0_rdata / m1_rdata  out  32: read data, valid when resp = 1, otherwise 0.
- m0_err / m1_err  out  1: address decode error, valid when resp = 1.
- u_raddr  out  32, u_rvalid  out  1: UART read port. rvalid pops the RX FIFO.
- u_rdata  in  32: UART read data, combinational; 32'hff when RX is empty.
- u_waddr  out  32, u_wdata  out  32, u_wvalid  out  1: UART write port.

## Operation
- States: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE, no valid: stay in IDLE.
- IDLE, any valid: choose a winner.
  - One valid: that master wins.
  - Both valid: the master that was not granted last wins. `last` resets to 1, so m0 wins the first tie.
- Grant actions in IDLE:
  - Assert the winner's ready for that cycle.
  - Latch wen, addr, wdata and the winner id.
  - Compute hit = (addr == SERIAL_PORT).
  - Update `last` to the winner.
  - Go to ISSUE.
- ISSUE, hit read: drive u_raddr = addr and u_rvalid = 1 for exactly this cycle. Capture u_rdata into the response register on the closing edge. Go to RESP.
- ISSUE, hit write: drive u_waddr = addr, u_wdata = wdata, u_wvalid = 1 for exactly this cycle. Response data = 0. Go to RESP.
- ISSUE, miss: no strobe is issued. Set err = 1, response data = 0. Go to RESP.
- RESP: assert resp, rdata and err to the granted master only. The other master's outputs stay 0. Go to IDLE.
- Strobes, u_* addresses/data and all response outputs are registered. They are 0 whenever not actively driven.
- Write drops: the UART silently drops writes when its TX FIFO is full. The arbiter does not detect this; resp is still returned with err = 0.
- Empty-RX read: returns 32'hff, err = 0. This is not an error.
- Mid-request changes: a master may change addr/wen while waiting for ready. Only the values present at the grant cycle are used.
- Reset low in any state:
  - State goes to IDLE, `last` to 1, all outputs to 0 immediately.
  - An ISSUE strobe in flight is withdrawn.
  - No response is produced for the aborted transaction.

## Timing
- Grant at cycle T (ready = 1). Strobe at T+1. resp at T+2. IDLE again at T+3.
- Next grant at T+3 at the earliest. Peak throughput is one transaction per 3 cycles.
- Exactly one u_rvalid or u_wvalid pulse per hit transaction. The two are never high together, and never high for more than one cycle.
- Fairness: with both masters continuously valid, grants alternate m0, m1, m0, ... Worst-case wait for a ready is 3 cycles after the other master's grant.
- The ready outputs are 0 in ISSUE and RESP, even if valid is asserted.
- Reset values: state IDLE, last = 1, and every output listed above is 0.

## Test plan
- Single write: m0 writes 0x41 to SERIAL_PORT.
  - Required: m0_ready at T; u_wvalid = 1 with u_wdata[7:0] = 0x41 at T+1; m0_resp = 1, m0_err = 0 at T+2.
- Read with RX empty: m1 reads SERIAL_PORT.
  - Required: u_rvalid for 1 cycle at T+1; m1_rdata = 32'hff, m1_err = 0 at T+2.
- Read with RX holding 0x5a: m0 reads SERIAL_PORT.
  - Required: m0_rdata = 32'h5a at T+2.
  - A second read then returns 32'hff, confirming exactly one pop.
- Bad address: m0 reads 32'ha0000000.
  - Required: no u_rvalid or u_wvalid at all; m0_resp = 1, m0_err = 1, m0_rdata = 0 at T+2.
- Contention: both masters continuously valid for 4 transactions each, starting right after reset.
  - Required: grant order m0, m1, m0, m1, ...; ready pulses spaced exactly 3 cycles apart.
- Reset abort: pull reset low during ISSUE of a write.
  - Required: u_wvalid drops to 0 the same cycle; no resp is produced.
  - After release, the first tie is granted to m0.
